// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the 4-bit ALU slice.
//   - alu_op_e : operation encoding carried on the 2-bit opcode bus
//   - ALU_OP_W : width of the opcode bus
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU datapath. It has no state.
//   Ports:
//     A      in  WIDTH    operand A, unsigned
//     B      in  WIDTH    operand B, unsigned
//     op     in  alu_op_e operation select
//     result out WIDTH+1  result; the top bit is the add carry-out or the
//                         subtract borrow, and it is 0 for the logic ops
// ----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  alu_op_e          op,
    output logic [WIDTH:0]   result
);

    logic [WIDTH:0] a_ext_s;
    logic [WIDTH:0] b_ext_s;
    logic [WIDTH:0] result_s;

    // Zero-extend both operands so that the top bit of an add holds the carry
    // and the top bit of a subtract holds the borrow (A < B).
    assign a_ext_s = {1'b0, A};
    assign b_ext_s = {1'b0, B};

    // Operation select
    always_comb begin
        result_s = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD:  result_s = a_ext_s + b_ext_s;
            OP_SUB:  result_s = a_ext_s - b_ext_s;
            OP_AND:  result_s = {1'b0, A & B};
            OP_OR:   result_s = {1'b0, A | B};
            default: result_s = {(WIDTH+1){1'b0}};
        endcase
    end

    assign result = result_s;

endmodule : alu_core

// File: rtl/alu_4bit.sv
// ----------------------------------------------------------------------------
// alu_4bit
//   Registered two-operand ALU (ADD, SUB, AND, OR). It has one cycle of
//   latency: C after edge N reflects the A, B and opcode values sampled at
//   edge N. A new operation is accepted on every clock. C comes only from
//   the register, so there is no combinational path from the inputs to C.
//   Ports:
//     clk     in  1        clock; all state changes on the rising edge
//     rst     in  1        synchronous, active-high reset. It has priority
//                          over any operation and clears C to 0.
//     A       in  WIDTH    operand A, unsigned
//     B       in  WIDTH    operand B, unsigned
//     opcode  in  2        00 ADD, 01 SUB, 10 AND, 11 OR
//     C       out WIDTH+1  registered result
// ----------------------------------------------------------------------------
module alu_4bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [ALU_OP_W-1:0] opcode,
    output logic [WIDTH:0]      C
);

    logic [WIDTH:0] result_s;
    logic [WIDTH:0] c_r;

    alu_core #(
        .WIDTH  (WIDTH)
    ) u_alu_core (
        .A      (A),
        .B      (B),
        .op     (alu_op_e'(opcode)),
        .result (result_s)
    );

    // Output register; reset has priority over the operation in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            c_r <= {(WIDTH+1){1'b0}};
        end else begin
            c_r <= result_s;
        end
    end

    assign C = c_r;

endmodule : alu_4bit

// File: tb/tb_alu_4bit.sv
// ----------------------------------------------------------------------------
// tb_alu_4bit
//   Self-checking bench for alu_4bit. It uses directed vectors and a
//   randomized stream, both checked against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_alu_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] a_s;
    logic [3:0] b_s;
    logic [1:0] opcode_s;
    logic [4:0] c_s;

    int n_compared;
    int n_mismatched;
    int n_carry;
    int n_borrow;
    int n_nocarry;
    int n_noborrow;
    int op_seen [4];

    alu_4bit #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (a_s),
        .B      (b_s),
        .opcode (opcode_s),
        .C      (c_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, reduced modulo 32
    function automatic logic [4:0] model(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = (a - b + 32) % 32;
            2:       r = a & b;
            3:       r = a | b;
            default: r = 0;
        endcase
        return r[4:0];
    endfunction

    task automatic check_result(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 5'h%02h, expected 5'h%02h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs, clock once, then sample 1 time unit after the edge
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input string tag);
        logic [4:0] exp;
        rst      = r;
        a_s      = a;
        b_s      = b;
        opcode_s = op;
        exp = r ? 5'h00 : model(int'(a), int'(b), int'(op));
        @(posedge clk);
        #1;
        check_result(tag, c_s, exp);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        n_carry = 0; n_borrow = 0; n_nocarry = 0; n_noborrow = 0;
        foreach (op_seen[i]) op_seen[i] = 0;
        rst = 1'b1; a_s = 4'h0; b_s = 4'h0; opcode_s = 2'b00;

        // Reset is held for three edges while a valid ADD is present on the inputs
        for (int i = 0; i < 3; i++) step(1'b1, 4'h2, 4'h1, 2'b00, "reset");

        // Directed vectors
        step(1'b0, 4'h2, 4'h1, 2'b00, "add_2_1");
        check_result("add_2_1_const", c_s, 5'h03);
        step(1'b0, 4'hF, 4'hF, 2'b00, "add_carry");
        check_result("add_carry_const", c_s, 5'h1E);
        step(1'b0, 4'h4, 4'h3, 2'b01, "sub_4_3");
        check_result("sub_4_3_const", c_s, 5'h01);
        step(1'b0, 4'h3, 4'h5, 2'b01, "sub_borrow");
        check_result("sub_borrow_const", c_s, 5'h1E);
        step(1'b0, 4'h7, 4'h7, 2'b01, "sub_equal");
        check_result("sub_equal_const", c_s, 5'h00);
        step(1'b0, 4'h9, 4'h6, 2'b10, "and_9_6");
        check_result("and_9_6_const", c_s, 5'h00);
        step(1'b0, 4'hF, 4'hA, 2'b11, "or_f_a");
        check_result("or_f_a_const", c_s, 5'h0F);

        // Reset asserted mid-stream, then released
        step(1'b0, 4'hC, 4'h5, 2'b00, "pre_rst");
        step(1'b1, 4'hC, 4'h5, 2'b00, "mid_rst");
        step(1'b0, 4'h8, 4'h9, 2'b00, "post_rst");
        check_result("post_rst_const", c_s, 5'h11);

        // Randomized stream: inputs change every cycle, with rare reset pulses
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] ra, rb;
            logic [1:0] rop;
            logic       rr;
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 2'($urandom_range(0, 3));
            rr  = ($urandom_range(0, 49) == 0);
            if (!rr) begin
                op_seen[rop]++;
                if (rop == 2'b00) begin
                    if (int'(ra) + int'(rb) > 15) n_carry++; else n_nocarry++;
                end
                if (rop == 2'b01) begin
                    if (ra < rb) n_borrow++; else n_noborrow++;
                end
            end
            step(rr, ra, rb, rop, "random");
        end

        $display("random coverage: add=%0d sub=%0d and=%0d or=%0d carry=%0d/%0d borrow=%0d/%0d",
                 op_seen[0], op_seen[1], op_seen[2], op_seen[3],
                 n_carry, n_nocarry, n_borrow, n_noborrow);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_alu_4bit
